// File: rtl/pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// pipe_stage_bank
//
// Parametrised N-lane pipeline register stage. One instance sits between two
// adjacent core pipeline stages (F2/DEC, DEC/ISS, ISS/EX, EX/LSU, LSU/WB) and
// carries a bundle of LANES lanes, each with a valid bit and a payload, plus
// the PC of the oldest lane. Lane 0 is the oldest lane of the bundle.
//
// Per-cycle priority: reset_i > flush_i > squash_i > stall_i > load.
//   flush_i  : every lane becomes invalid; the PC register holds.
//   squash_i : with m the lowest set bit, every held lane j > m is killed.
//              Lanes 0..m either hold (stall_i) or load as usual.
//   stall_i  : every register holds, including the PC.
//   load     : lane k takes valid_i[k] && !bubble_i[k] and its payload.
//
// Ports:
//   clock_i      in   core clock
//   reset_i      in   synchronous active-high reset
//   stall_i      in   hold the stage contents
//   flush_i      in   invalidate every lane
//   bubble_i     in   [LANES]          load an empty lane instead of lane k
//   squash_i     in   [LANES]          kill held lanes younger than lane k
//   valid_i      in   [LANES]          incoming per-lane valid
//   data_i       in   [LANES*DATA_W]   lane k at [k*DATA_W +: DATA_W]
//   pc_i         in   [PC_W]           PC of incoming lane 0
//   valid_o      out  [LANES]          registered per-lane valid
//   data_o       out  [LANES*DATA_W]   registered payload
//   pc_o         out  [LANES*PC_W]     lane k = registered PC + 4*k
//   stall_cnt_o  out  [CNT_W]          saturating count of stalled cycles
//                                      holding at least one valid lane
//   bubble_cnt_o out  [CNT_W]          saturating count of bubbled / squashed
//                                      lanes
//
// CLEAR_ON_KILL selects whether a killed or bubbled lane has its payload
// zeroed (1) or held (0); its valid bit clears either way.
// -----------------------------------------------------------------------------
module pipe_stage_bank #(
    parameter int unsigned LANES         = 2,
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned PC_W          = 32,
    parameter bit          CLEAR_ON_KILL = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic [LANES-1:0]        bubble_i,
    input  logic [LANES-1:0]        squash_i,
    input  logic [LANES-1:0]        valid_i,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic [PC_W-1:0]         pc_i,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [LANES*PC_W-1:0]   pc_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    output logic [CNT_W-1:0]        bubble_cnt_o
);

    // Wide enough to count every lane once per cycle (a lane is either
    // killed or loaded, never both, so the per-cycle increment is <= LANES).
    localparam int unsigned INC_W = $clog2(LANES + 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [LANES-1:0]             valid_q;
    logic [LANES-1:0][DATA_W-1:0] data_q;
    logic [PC_W-1:0]              pc_q;
    logic [CNT_W-1:0]             stall_cnt_q;
    logic [CNT_W-1:0]             bubble_cnt_q;

    // -------------------------------------------------------------------------
    // Next-state
    // -------------------------------------------------------------------------
    logic [LANES-1:0]             valid_d;
    logic [LANES-1:0][DATA_W-1:0] data_d;
    logic [PC_W-1:0]              pc_d;
    logic [LANES-1:0]             kill;
    logic [INC_W-1:0]             bubble_inc;
    logic                         stall_inc;
    logic                         squash_seen;

    // Value a dead lane's payload takes: zero, or its current contents.
    function automatic logic [DATA_W-1:0] dead_payload(input logic [DATA_W-1:0] cur);
        return (CLEAR_ON_KILL != 1'b0) ? '0 : cur;
    endfunction

    // Saturating add; the carry-out bit flags an overflow past all-ones.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // NOTE: combinational logic uses blocking assignments, and every variable
    // gets a default at the top so no path can leave it unassigned (a latch).
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        pc_d        = pc_q;
        kill        = '0;
        bubble_inc  = '0;
        squash_seen = 1'b0;

        // Lane j dies when any older lane 0..j-1 requests a squash, which is
        // exactly "j > lowest set index". A squash on the top lane kills
        // nothing.
        for (int j = 0; j < LANES; j++) begin
            kill[j]     = squash_seen;
            squash_seen = squash_seen | squash_i[j];
        end

        for (int k = 0; k < LANES; k++) begin
            if (flush_i) begin
                valid_d[k] = 1'b0;
                data_d[k]  = dead_payload(data_q[k]);
            end else if (kill[k]) begin
                // Squash beats both stall and load; only lanes that actually
                // held an instruction count as killed.
                valid_d[k] = 1'b0;
                data_d[k]  = dead_payload(data_q[k]);
                if (valid_q[k]) begin
                    bubble_inc = bubble_inc + INC_W'(1);
                end
            end else if (!stall_i) begin
                if (bubble_i[k]) begin
                    valid_d[k] = 1'b0;
                    data_d[k]  = dead_payload(data_q[k]);
                    // Count only lanes the bubble actually invalidated.
                    if (valid_i[k]) begin
                        bubble_inc = bubble_inc + INC_W'(1);
                    end
                end else begin
                    valid_d[k] = valid_i[k];
                    data_d[k]  = data_i[k*DATA_W +: DATA_W];
                end
            end
        end

        // The bundle PC follows the load path only; flush and stall hold it,
        // while a squash alongside a load still takes the new PC.
        if (!flush_i && !stall_i) begin
            pc_d = pc_i;
        end
    end

    assign stall_inc = stall_i && !flush_i && (|valid_q);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            // NOTE: the payload array is reset too, because data_o must read
            // zero straight out of reset; it is small flop storage, not a RAM.
            valid_q      <= '0;
            data_q       <= '0;
            pc_q         <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
            if (stall_inc) begin
                stall_cnt_q <= sat_add(stall_cnt_q, INC_W'(1));
            end
            bubble_cnt_q <= sat_add(bubble_cnt_q, bubble_inc);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

    // Per-lane PC is the registered bundle PC plus a constant lane offset;
    // the add wraps modulo 2^PC_W.
    for (genvar g = 0; g < LANES; g++) begin : g_lane_pc
        assign pc_o[g*PC_W +: PC_W] = pc_q + PC_W'(4 * g);
    end

endmodule

// File: tb/tb_pipe_stage_bank.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_bank
//
// Directed bench for a two-lane, 64-bit payload, 32-bit PC stage with
// CLEAR_ON_KILL=1 and 4-bit counters (so stall saturation is reachable).
// Expected values are written by hand next to each step.
// -----------------------------------------------------------------------------
module tb_pipe_stage_bank;

    localparam int unsigned LANES  = 2;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned CNT_W  = 4;

    logic                    clock_i = 1'b0;
    logic                    reset_i;
    logic                    stall_i;
    logic                    flush_i;
    logic [LANES-1:0]        bubble_i;
    logic [LANES-1:0]        squash_i;
    logic [LANES-1:0]        valid_i;
    logic [LANES*DATA_W-1:0] data_i;
    logic [PC_W-1:0]         pc_i;
    logic [LANES-1:0]        valid_o;
    logic [LANES*DATA_W-1:0] data_o;
    logic [LANES*PC_W-1:0]   pc_o;
    logic [CNT_W-1:0]        stall_cnt_o;
    logic [CNT_W-1:0]        bubble_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_stage_bank #(
        .LANES         (LANES),
        .DATA_W        (DATA_W),
        .PC_W          (PC_W),
        .CLEAR_ON_KILL (1'b1),
        .CNT_W         (CNT_W)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .bubble_i     (bubble_i),
        .squash_i     (squash_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .pc_i         (pc_i),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .pc_o         (pc_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it, and the next
    // inputs are driven from there, well clear of the following edge.
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic [1:0] bub,
                         input logic [1:0] sq, input logic [1:0] vi,
                         input logic [63:0] d1, input logic [63:0] d0,
                         input logic [31:0] pc);
        stall_i  = st;
        flush_i  = fl;
        bubble_i = bub;
        squash_i = sq;
        valid_i  = vi;
        data_i   = {d1, d0};
        pc_i     = pc;
    endtask

    initial begin
        // ---- reset with live-looking inputs ----
        reset_i = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 64'h5A5A, 64'hA5A5, 32'h55);
        step();
        check("rst_valid",  valid_o,      2'b00);
        check("rst_data",   data_o,       128'h0);
        check("rst_pc",     pc_o,         {32'h4, 32'h0});
        check("rst_stall",  stall_cnt_o,  4'd0);
        check("rst_bubble", bubble_cnt_o, 4'd0);

        // ---- load ----
        reset_i = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 64'hBB, 64'hAA, 32'h100);
        step();
        check("load_valid", valid_o, 2'b11);
        check("load_data",  data_o,  {64'hBB, 64'hAA});
        check("load_pc",    pc_o,    {32'h104, 32'h100});

        // ---- three stalled cycles with changed inputs ----
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 64'h22, 64'h11, 32'h200);
        for (int i = 0; i < 3; i++) step();
        check("stall_valid", valid_o,     2'b11);
        check("stall_data",  data_o,      {64'hBB, 64'hAA});
        check("stall_pc",    pc_o,        {32'h104, 32'h100});
        check("stall_cnt3",  stall_cnt_o, 4'd3);

        // ---- bubble lane 1 ----
        drive(1'b0, 1'b0, 2'b10, 2'b00, 2'b11, 64'hDD, 64'hCC, 32'h300);
        step();
        check("bub_valid", valid_o,      2'b01);
        check("bub_data",  data_o,       {64'h0, 64'hCC});
        check("bub_pc",    pc_o,         {32'h304, 32'h300});
        check("bub_cnt",   bubble_cnt_o, 4'd1);
        check("bub_stall", stall_cnt_o,  4'd3);

        // ---- refill both lanes ----
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 64'h22, 64'h11, 32'h400);
        step();
        check("refill_valid", valid_o, 2'b11);

        // ---- squash lane 0 under stall: lane 1 dies, lane 0 holds ----
        drive(1'b1, 1'b0, 2'b00, 2'b01, 2'b11, 64'h44, 64'h33, 32'h480);
        step();
        check("sqst_valid",  valid_o,      2'b01);
        check("sqst_data",   data_o,       {64'h0, 64'h11});
        check("sqst_pc",     pc_o,         {32'h404, 32'h400});
        check("sqst_bubble", bubble_cnt_o, 4'd2);
        check("sqst_stall",  stall_cnt_o,  4'd4);

        // ---- squash on the top lane is a no-op; plain load ----
        drive(1'b0, 1'b0, 2'b00, 2'b10, 2'b11, 64'h66, 64'h55, 32'h500);
        step();
        check("sqtop_valid",  valid_o,      2'b11);
        check("sqtop_data",   data_o,       {64'h66, 64'h55});
        check("sqtop_bubble", bubble_cnt_o, 4'd2);

        // ---- squash with load: lane 0 loads, loaded lane 1 forced dead ----
        drive(1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 64'h88, 64'h77, 32'h600);
        step();
        check("sqld_valid",  valid_o,      2'b01);
        check("sqld_data",   data_o,       {64'h0, 64'h77});
        check("sqld_pc",     pc_o,         {32'h604, 32'h600});
        check("sqld_bubble", bubble_cnt_o, 4'd3);

        // ---- refill, then flush while stalled ----
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 64'hAB, 64'h99, 32'h700);
        step();
        check("refill2_valid", valid_o, 2'b11);
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 64'hEE, 64'hFF, 32'h800);
        step();
        check("flush_valid",  valid_o,      2'b00);
        check("flush_data",   data_o,       128'h0);
        check("flush_pc",     pc_o,         {32'h704, 32'h700});
        check("flush_stall",  stall_cnt_o,  4'd4);
        check("flush_bubble", bubble_cnt_o, 4'd3);

        // ---- stall with no valid lane does not count ----
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 64'h1, 64'h2, 32'h900);
        step();
        check("idle_stall", stall_cnt_o, 4'd4);

        // ---- one valid lane, then 20 stalled cycles: saturate at 15 ----
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 64'h34, 64'h12, 32'h800);
        step();
        check("sat_load", valid_o, 2'b01);
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 64'h0, 64'h0, 32'h0);
        for (int i = 0; i < 20; i++) step();
        check("sat_stall", stall_cnt_o, 4'd15);
        check("sat_valid", valid_o,     2'b01);

        // ---- PC wrap across lanes ----
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 64'h3, 64'h4, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc_o, {32'h0000_0000, 32'hFFFF_FFFC});

        // ---- reset while stalling and flushing: clean reset state ----
        reset_i = 1'b1;
        drive(1'b1, 1'b1, 2'b11, 2'b01, 2'b11, 64'h7, 64'h8, 32'h1234);
        step();
        check("rst2_valid",  valid_o,      2'b00);
        check("rst2_data",   data_o,       128'h0);
        check("rst2_pc",     pc_o,         {32'h4, 32'h0});
        check("rst2_stall",  stall_cnt_o,  4'd0);
        check("rst2_bubble", bubble_cnt_o, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised N-lane pipeline register stage; successor to the fixed dual-slot inter-stage buffers in the core pipeline.
- One instance replaces each hand-written F2/DEC, DEC/ISS, ISS/EX, EX/LSU and LSU/WB buffer pair.
- Adds per-lane valid bits, a global hold, a flush, per-lane bubble injection and intra-bundle younger-lane squash.
- Adds saturating stall and bubble counters for performance observation.

Parameters:
- LANES, 2, number of issue lanes (1..4); lane 0 is oldest.
- DATA_W, 64, per-lane payload width (instruction, control, ALU result, etc.).
- PC_W, 32, bundle PC width.
- CLEAR_ON_KILL, 1, if 1 the payload of a killed or bubbled lane is zeroed; if 0 the payload is held and only the valid bit clears.
- CNT_W, 16, width of the performance counters.

Ports:
- clock_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hold: the stage keeps its contents.
- flush_i  in  1  invalidate every lane (wrong-branch / redirect).
- bubble_i  in  LANES  per-lane: load an empty lane instead of the input lane.
- squash_i  in  LANES  per-lane: kill all lanes younger than this lane currently held in the stage.
- valid_i  in  LANES  per-lane input valid.
- data_i  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- pc_i  in  PC_W  PC of lane 0 of the incoming bundle.
- valid_o  out  LANES  registered per-lane valid.
- data_o  out  LANES*DATA_W  registered payload.
- pc_o  out  LANES*PC_W  per-lane PC; lane k = registered bundle PC + 4*k, modulo 2^PC_W.
- stall_cnt_o  out  CNT_W  number of cycles with stall_i=1 and at least one valid lane.
- bubble_cnt_o  out  CNT_W  number of lanes bubbled or squashed.

Behaviour:
- Reset values: valid_o=0, data_o=0, bundle PC register=0 (so pc_o lane k = 4*k), counters=0.
- Latency: one cycle from input to output.
- Priority per cycle: reset_i > flush_i > squash_i > stall_i > load.
- flush_i=1: all valid_o clear next cycle, regardless of stall_i. Payload is zeroed if CLEAR_ON_KILL=1. The PC register is unchanged.
- squash_i: let m = lowest set index. Lanes j>m clear valid (payload zeroed per CLEAR_ON_KILL), regardless of stall_i. Lanes 0..m are unaffected by the squash; they hold if stall_i=1, otherwise they load.
- When squash_i and a load happen in the same cycle, the loaded lanes j>m are also forced invalid.
- Setting squash_i at the top lane index is a no-op.
- stall_i=1 (no flush, no squash): every register holds, including the PC.
- Load (stall_i=0):
  - Lane k valid_o <= valid_i[k] && !bubble_i[k].
  - Payload <= data_i lane k, or zero/hold for a bubbled lane per CLEAR_ON_KILL.
  - PC register <= pc_i.
- Bubbling all lanes still loads the PC.
- stall_cnt_o: increments when stall_i=1, !flush_i, and |valid_o. It saturates at 2^CNT_W-1 and does not wrap.
- bubble_cnt_o: adds the number of lanes newly invalidated this cycle by bubble_i (only counted when loading) plus the number of valid lanes killed by squash_i. It saturates. It is not incremented by flush_i.
- Both counters are cleared only by reset_i.
- Reset asserted mid-stall or mid-flush: the next state is the reset state; no partial update.
- Combinational paths input→output: none. All outputs are registered, except pc_o lane offsets, which are the registered PC plus a constant.

Test Plan:
- Reset: LANES=2. Hold reset_i one cycle with valid_i=2'b11, data_i nonzero → valid_o=0, data_o=0, pc_o={32'h4,32'h0}, counters 0.
- Load then stall:
  - Cycle 1: pc_i=32'h100, valid_i=11, data_i lanes 0xAA/0xBB → valid_o=11, pc_o lanes 0x100/0x104.
  - Next 3 cycles: stall_i=1 with changed inputs → outputs unchanged, stall_cnt_o=3.
- Bubble: bubble_i=2'b10, valid_i=11, stall_i=0 → valid_o=01, lane1 payload=0 (CLEAR_ON_KILL=1), bubble_cnt_o +1.
- Squash under stall:
  - Setup: stage holds valid_o=11; assert stall_i=1 and squash_i=01.
  - Response: valid_o=01 next cycle, lane0 payload unchanged, bubble_cnt_o +1.
- Flush vs stall: flush_i=1 and stall_i=1 with valid_o=11 → valid_o=00 next cycle, PC unchanged, stall_cnt_o not incremented.
- Saturation and wrap:
  - Counter: CNT_W=4, stall 20 cycles with a valid lane → stall_cnt_o=15.
  - PC wrap: pc_i=32'hFFFF_FFFC, LANES=2 → lane1 pc_o=32'h0000_0000.
